// File: rtl/clk_gate_ctrl.sv
// Clock-enable sequencer: serves per-domain req/ack handshakes one at a time,
// round-robin, with a fixed settle delay between clk_en and ack edges.
module clk_gate_ctrl #(
    parameter int unsigned N_CH   = 4,
    parameter int unsigned SETTLE = 3,
    parameter int unsigned SEL_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_CH-1:0]   req,
    output logic [N_CH-1:0]   ack,
    output logic [N_CH-1:0]   clk_en,
    output logic              busy,
    output logic [SEL_W-1:0]  sel
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ON_WAIT  = 2'd1,
        ST_OFF_WAIT = 2'd2
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [N_CH-1:0]   r_ack, w_ack_nxt;
    logic [N_CH-1:0]   r_clk_en, w_clk_en_nxt;
    logic              r_busy, w_busy_nxt;
    logic [SEL_W-1:0]  r_sel, w_sel_nxt;
    logic [SEL_W-1:0]  r_rr, w_rr_nxt;

    logic [N_CH-1:0]   w_pend;
    logic              w_hit;
    logic [SEL_W-1:0]  w_hit_idx;
    logic [SEL_W-1:0]  w_scan;
    logic [SEL_W-1:0]  w_rr_adv;

    assign w_pend = req ^ r_ack;

    // First pending domain at or after r_rr, wrapping modulo N_CH
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        w_scan    = r_rr;
        for (int unsigned k = 0; k < N_CH; k++) begin
            if (!w_hit && w_pend[w_scan]) begin
                w_hit     = 1'b1;
                w_hit_idx = w_scan;
            end
            if (w_scan == SEL_W'(N_CH - 1)) begin
                w_scan = '0;
            end else begin
                w_scan = w_scan + SEL_W'(1);
            end
        end
    end

    assign w_rr_adv = (w_hit_idx == SEL_W'(N_CH - 1)) ? '0 : (w_hit_idx + SEL_W'(1));

    // Next-state and output-register logic
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_ack_nxt    = r_ack;
        w_clk_en_nxt = r_clk_en;
        w_busy_nxt   = r_busy;
        w_sel_nxt    = r_sel;
        w_rr_nxt     = r_rr;
        case (r_state)
            ST_IDLE: begin
                if (w_hit) begin
                    w_sel_nxt  = w_hit_idx;
                    w_busy_nxt = 1'b1;
                    w_rr_nxt   = w_rr_adv;
                    w_cnt_nxt  = CNT_W'(SETTLE - 1);
                    if (req[w_hit_idx]) begin
                        w_state_nxt             = ST_ON_WAIT;
                        w_clk_en_nxt[w_hit_idx] = 1'b1;
                    end else begin
                        w_state_nxt          = ST_OFF_WAIT;
                        w_ack_nxt[w_hit_idx] = 1'b0;
                    end
                end
            end
            ST_ON_WAIT: begin
                if (r_cnt == '0) begin
                    w_ack_nxt[r_sel] = 1'b1;
                    w_busy_nxt       = 1'b0;
                    w_state_nxt      = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            ST_OFF_WAIT: begin
                if (r_cnt == '0) begin
                    w_clk_en_nxt[r_sel] = 1'b0;
                    w_busy_nxt          = 1'b0;
                    w_state_nxt         = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_ack    <= '0;
            r_clk_en <= '0;
            r_busy   <= 1'b0;
            r_sel    <= '0;
            r_rr     <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_ack    <= w_ack_nxt;
            r_clk_en <= w_clk_en_nxt;
            r_busy   <= w_busy_nxt;
            r_sel    <= w_sel_nxt;
            r_rr     <= w_rr_nxt;
        end
    end

    assign ack    = r_ack;
    assign clk_en = r_clk_en;
    assign busy   = r_busy;
    assign sel    = r_sel;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Bench for clk_gate_ctrl: directed req patterns, expected completions queued
// by the stimulus and checked by an independent monitor on busy falling edges.
module tb_clk_gate_ctrl;

    localparam int unsigned N_CH   = 4;
    localparam int unsigned SETTLE = 3;
    localparam int unsigned SEL_W  = 2;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b1;
    logic [N_CH-1:0]  req   = '0;
    logic [N_CH-1:0]  ack;
    logic [N_CH-1:0]  clk_en;
    logic             busy;
    logic [SEL_W-1:0] sel;

    always #5 clk = ~clk;

    clk_gate_ctrl #(.N_CH(N_CH), .SETTLE(SETTLE), .SEL_W(SEL_W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .ack    (ack),
        .clk_en (clk_en),
        .busy   (busy),
        .sel    (sel)
    );

    typedef struct packed {
        logic [SEL_W-1:0] sel;
        logic [N_CH-1:0]  ack;
        logic [N_CH-1:0]  clk_en;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;
    int   busy_cyc = 0;
    logic prev_busy = 1'b0;
    int   tog [N_CH];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic push(input logic [SEL_W-1:0] s, input logic [N_CH-1:0] a, input logic [N_CH-1:0] c);
        exp_t e;
        e.sel    = s;
        e.ack    = a;
        e.clk_en = c;
        exp_q.push_back(e);
    endtask

    // Land #1 after the n-th upcoming rising edge
    task automatic to_edge(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_quiet(input int max_cyc);
        int cyc = 0;
        while ((busy || (req !== ack) || (exp_q.size() != 0)) && cyc < max_cyc) begin
            @(negedge clk);
            cyc++;
        end
        chk("quiet_timeout", 32'(cyc >= max_cyc), 32'(0));
    endtask

    // Monitor: ordering invariant each cycle, transaction check when busy falls
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_busy = 1'b0;
            busy_cyc  = 0;
        end else begin
            chk("ack_without_clk_en", 32'(ack & ~clk_en), 32'(0));
            if (busy) busy_cyc++;
            if (prev_busy && !busy) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_completion", 32'(sel), 32'hFFFF_FFFF);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("done_sel",    32'(sel),    32'(mon_e.sel));
                    chk("done_ack",    32'(ack),    32'(mon_e.ack));
                    chk("done_clk_en", 32'(clk_en), 32'(mon_e.clk_en));
                    chk("busy_cycles", 32'(busy_cyc), 32'(SETTLE));
                end
                busy_cyc = 0;
            end
            prev_busy = busy;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #1 rst_n = 1'b0;
        #1;
        chk("rst_ack",    32'(ack),    32'(0));
        chk("rst_clk_en", 32'(clk_en), 32'(0));
        chk("rst_busy",   32'(busy),   32'(0));
        chk("rst_sel",    32'(sel),    32'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Single request on domain 1
        @(negedge clk);
        req = 4'b0010;
        push(2'd1, 4'b0010, 4'b0010);
        to_edge(1);
        chk("t1_clk_en_e0", 32'(clk_en), 32'(4'b0010));
        chk("t1_ack_e0",    32'(ack),    32'(4'b0000));
        chk("t1_busy_e0",   32'(busy),   32'(1));
        chk("t1_sel_e0",    32'(sel),    32'(1));
        to_edge(2);
        chk("t1_ack_e2",    32'(ack),    32'(4'b0000));
        to_edge(1);
        chk("t1_ack_e3",    32'(ack),    32'(4'b0010));
        chk("t1_busy_e3",   32'(busy),   32'(0));
        wait_quiet(100);

        // Release domain 1
        @(negedge clk);
        req = 4'b0000;
        push(2'd1, 4'b0000, 4'b0000);
        to_edge(1);
        chk("t2_ack_e0",    32'(ack),    32'(4'b0000));
        chk("t2_clk_en_e0", 32'(clk_en), 32'(4'b0010));
        to_edge(3);
        chk("t2_clk_en_e3", 32'(clk_en), 32'(4'b0000));
        wait_quiet(100);

        // Round-robin with rr=2: every domain toggles twice as soon as it is served
        push(2'd2, 4'b0100, 4'b0100);
        push(2'd3, 4'b1100, 4'b1100);
        push(2'd0, 4'b1101, 4'b1101);
        push(2'd1, 4'b1111, 4'b1111);
        push(2'd2, 4'b1011, 4'b1011);
        push(2'd3, 4'b0011, 4'b0011);
        push(2'd0, 4'b0010, 4'b0010);
        push(2'd1, 4'b0000, 4'b0000);
        for (int i = 0; i < int'(N_CH); i++) tog[i] = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < int'(N_CH); i++) begin
                if (req[i] == ack[i] && tog[i] < 2) begin
                    req[i] = ~req[i];
                    tog[i]++;
                end
            end
            if (tog[0] == 2 && tog[1] == 2 && tog[2] == 2 && tog[3] == 2) break;
        end
        wait_quiet(200);

        // Simultaneous requests from rr=0
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        req = 4'b0101;
        push(2'd0, 4'b0001, 4'b0001);
        push(2'd2, 4'b0101, 4'b0101);
        to_edge(4);
        chk("t3_ack_e3",    32'(ack),    32'(4'b0001));
        chk("t3_clk_en_e3", 32'(clk_en), 32'(4'b0001));
        chk("t3_busy_e3",   32'(busy),   32'(0));
        to_edge(1);
        chk("t3_clk_en_e4", 32'(clk_en), 32'(4'b0101));
        chk("t3_sel_e4",    32'(sel),    32'(2));
        to_edge(3);
        chk("t3_ack_e7",    32'(ack),    32'(4'b0101));
        wait_quiet(100);

        // rr=3 now: releasing both serves domain 0 before domain 2
        @(negedge clk);
        req = 4'b0000;
        push(2'd0, 4'b0100, 4'b0100);
        push(2'd2, 4'b0000, 4'b0000);
        wait_quiet(100);

        // Request dropped mid turn-on on domain 3
        @(negedge clk);
        req = 4'b1000;
        push(2'd3, 4'b1000, 4'b1000);
        push(2'd3, 4'b0000, 4'b0000);
        @(negedge clk);
        req = 4'b0000;
        to_edge(3);
        chk("t4_ack_e3",    32'(ack),    32'(4'b1000));
        to_edge(1);
        chk("t4_ack_e4",    32'(ack),    32'(4'b0000));
        chk("t4_clk_en_e4", 32'(clk_en), 32'(4'b1000));
        to_edge(3);
        chk("t4_clk_en_e7", 32'(clk_en), 32'(4'b0000));
        wait_quiet(100);

        // Async reset mid ON_WAIT on domain 1 (rr becomes 2 before reset)
        @(negedge clk);
        req = 4'b0010;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_clk_en", 32'(clk_en), 32'(0));
        chk("t5_rst_ack",    32'(ack),    32'(0));
        chk("t5_rst_busy",   32'(busy),   32'(0));
        chk("t5_rst_sel",    32'(sel),    32'(0));
        #5;
        req = 4'b1010;
        push(2'd1, 4'b0010, 4'b0010);
        push(2'd3, 4'b1010, 4'b1010);
        rst_n = 1'b1;
        to_edge(1);
        chk("t5_clk_en_rel", 32'(clk_en), 32'(4'b0010));
        chk("t5_sel_rel",    32'(sel),    32'(1));
        chk("t5_busy_rel",   32'(busy),   32'(1));
        wait_quiet(100);

        @(negedge clk);
        req = 4'b0000;
        push(2'd1, 4'b1000, 4'b1000);
        push(2'd3, 4'b0000, 4'b0000);
        wait_quiet(100);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
